// File: rtl/rio_credit_pkg.sv
// Shared constants and credit word helpers for the RIO/GTP link credit engine.
// Word layout: [CW-1] even parity, [CW-2 -: VC_W] VC index + 1, [PTR_W-1:0] pointer.
package rio_credit_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  function automatic int vc_width(input int num_vc);
    return $clog2(num_vc + 1);
  endfunction

  function automatic int vc_lsb(input int cw, input int vc_w);
    return cw - 1 - vc_w;
  endfunction

  function automatic logic [31:0] credit_encode(input int cw, input int vc_w, input int ptr_w,
                                                input int vc, input int ptr);
    logic [31:0] w;
    logic [31:0] ptr_mask;
    ptr_mask  = (32'd1 << ptr_w) - 32'd1;
    w         = (32'(vc + 1) << vc_lsb(cw, vc_w)) | (32'(ptr) & ptr_mask);
    w[cw - 1] = ^w;
    return w;
  endfunction

  // True when the word is a usable credit: parity, VC range, pointer range, reserved bits clear.
  function automatic logic credit_check(input logic [31:0] w, input int cw, input int vc_w,
                                        input int ptr_w, input int num_vc, input int fifo_size);
    logic [31:0] ptr_mask;
    logic [31:0] vc_mask;
    logic [31:0] used_mask;
    logic [31:0] field;
    logic [31:0] ptr;
    ptr_mask  = (32'd1 << ptr_w) - 32'd1;
    vc_mask   = ((32'd1 << vc_w) - 32'd1) << vc_lsb(cw, vc_w);
    used_mask = ptr_mask | vc_mask | (32'd1 << (cw - 1));
    field     = (w & vc_mask) >> vc_lsb(cw, vc_w);
    ptr       = w & ptr_mask;
    return (^w == 1'b0) && (field >= 32'd1) && (field <= 32'(num_vc)) &&
           (ptr < 32'(fifo_size)) && ((w & ~used_mask) == 32'd0);
  endfunction

endpackage

// File: rtl/rio_credit_rr_arb.sv
// Round-robin arbiter over N requesters; search starts one past the last grant.
module rio_credit_rr_arb #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             update_i,
  output logic             gnt_valid_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [IDX_W-1:0] last_q;

  // Walk from farthest to nearest so the nearest requester overwrites earlier picks.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = last_q;
    for (int i = N; i >= 1; i--) begin
      if (req_i[(int'(last_q) + i) % N]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IDX_W'((int'(last_q) + i) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IDX_W'(N - 1);
    end else if (update_i && gnt_valid_o) begin
      last_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/rio_link_credits_nvc.sv
// N-VC link credit engine: remote FIFO occupancy/xoff tracking and outgoing credit generation.
// Optional rejected-credit counter is built when RIO_CREDIT_ERRCNT_EN is defined.
module rio_link_credits_nvc
  import rio_credit_pkg::*;
#(
  parameter int NUM_VC         = 3,
  parameter int FIFO_SIZE      = 6,
  parameter int PTR_W          = 3,
  parameter int FULL_THRESHOLD = 4,
  parameter int CREDIT_WIDTH   = 16,
  parameter int RETX_PERIOD    = 65536,
  parameter int GUARD_CYCLES   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_VC-1:0]       i_enq,
  input  logic [CREDIT_WIDTH-1:0] i_ds_credit,
  input  logic                    i_ds_credit_valid,
  input  logic [NUM_VC-1:0]       i_deq,
`ifdef RIO_CREDIT_ERRCNT_EN
  input  logic                    i_err_cnt_clr,
  output logic [15:0]             o_ds_credit_err_cnt,
`endif
  output logic [CREDIT_WIDTH-1:0] o_us_credit,
  output logic                    o_us_credit_valid,
  input  logic                    i_us_credit_accept,
  output logic [NUM_VC-1:0]       o_local_xoff,
  output logic                    o_ds_credit_err
);

  localparam int VC_W  = vc_width(NUM_VC);
  localparam int VC_LO = vc_lsb(CREDIT_WIDTH, VC_W);
  localparam int IDX_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_SIZE - 1);
  localparam logic [PTR_W:0]   FIFO_SZ  = (PTR_W + 1)'(FIFO_SIZE);
  localparam logic [PTR_W:0]   FULL_TH  = (PTR_W + 1)'(FULL_THRESHOLD);
  localparam int GC_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GC_W-1:0] GC_LAST = GC_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  logic              ds_ok, ds_acc, ds_bad, err_q;
  logic [VC_W-1:0]   ds_vc_field;
  logic [PTR_W-1:0]  ds_ptr;
  logic [PTR_W-1:0]  us_tail [NUM_VC];
  logic [NUM_VC-1:0] xoff_w, pend_w;
  logic              tick, gnt_valid, grant_fire;
  logic [IDX_W-1:0]  gnt_idx;

  assign ds_ok       = credit_check(32'(i_ds_credit), CREDIT_WIDTH, VC_W, PTR_W, NUM_VC, FIFO_SIZE);
  assign ds_vc_field = i_ds_credit[VC_LO +: VC_W];
  assign ds_ptr      = i_ds_credit[PTR_W-1:0];
  assign ds_acc      = i_ds_credit_valid & ds_ok;
  assign ds_bad      = i_ds_credit_valid & ~ds_ok;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, ust_q, ust_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic             xoff_q, pend_q, pend_d;

    always_comb begin
      head_d = head_q;
      if (i_enq[v]) head_d = (head_q == PTR_LAST) ? '0 : head_q + PTR_W'(1);
      tail_d = tail_q;
      if (ds_acc && ds_vc_field == VC_W'(v + 1)) tail_d = ds_ptr;
      ust_d = ust_q;
      if (i_deq[v]) ust_d = (ust_q == PTR_LAST) ? '0 : ust_q + PTR_W'(1);
      occ_d = (head_q >= tail_q) ? ({1'b0, head_q} - {1'b0, tail_q})
                                 : (FIFO_SZ + {1'b0, head_q} - {1'b0, tail_q});
      // A new dequeue or retransmit tick outranks the grant clearing this VC.
      pend_d = pend_q;
      if (grant_fire && gnt_idx == IDX_W'(v)) pend_d = 1'b0;
      if (i_deq[v] || tick) pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        head_q <= '0;
        tail_q <= '0;
        ust_q  <= '0;
        occ_q  <= '0;
        xoff_q <= 1'b1;
        pend_q <= 1'b0;
      end else begin
        head_q <= head_d;
        tail_q <= tail_d;
        ust_q  <= ust_d;
        occ_q  <= occ_d;
        xoff_q <= (occ_q > FULL_TH);
        pend_q <= pend_d;
      end
    end

    assign us_tail[v] = ust_q;
    assign xoff_w[v]  = xoff_q;
    assign pend_w[v]  = pend_q;
  end

  assign o_local_xoff = xoff_w;

  if (RETX_PERIOD > 0) begin : g_retx
    localparam int RC_W = (RETX_PERIOD > 1) ? $clog2(RETX_PERIOD) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RETX_PERIOD - 1);
    logic [RC_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt_q <= '0;
      else if (cnt_q == RC_LAST) cnt_q <= '0;
      else                       cnt_q <= cnt_q + RC_W'(1);
    end
    assign tick = (cnt_q == RC_LAST);
  end else begin : g_no_retx
    assign tick = 1'b0;
  end

  rio_credit_rr_arb #(.N(NUM_VC), .IDX_W(IDX_W)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (pend_w),
    .update_i   (grant_fire),
    .gnt_valid_o(gnt_valid),
    .gnt_idx_o  (gnt_idx)
  );

  // Handshake: o_us_credit is held stable while valid; a transfer happens on valid && accept.
  logic [1:0]              state_q, state_d;
  logic [CREDIT_WIDTH-1:0] out_q, out_d;
  logic [GC_W-1:0]         gcnt_q, gcnt_d;

  assign grant_fire = (state_q == ST_IDLE) && gnt_valid;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          out_d   = CREDIT_WIDTH'(credit_encode(CREDIT_WIDTH, VC_W, PTR_W, int'(gnt_idx),
                                                int'(us_tail[gnt_idx])));
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (i_us_credit_accept) begin
          out_d   = '0;
          gcnt_d  = '0;
          state_d = (GUARD_CYCLES > 0) ? ST_GUARD : ST_IDLE;
        end
      end
      ST_GUARD: begin
        if (gcnt_q == GC_LAST) state_d = ST_IDLE;
        else                   gcnt_d  = gcnt_q + GC_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      gcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      gcnt_q  <= gcnt_d;
      err_q   <= ds_bad;
    end
  end

  assign o_us_credit_valid = (state_q == ST_SEND);
  assign o_us_credit       = o_us_credit_valid ? out_q : '0;
  assign o_ds_credit_err   = err_q;

`ifdef RIO_CREDIT_ERRCNT_EN
  logic [15:0] errcnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               errcnt_q <= '0;
    else if (i_err_cnt_clr)                   errcnt_q <= '0;
    else if (ds_bad && errcnt_q != 16'hFFFF)  errcnt_q <= errcnt_q + 16'd1;
  end
  assign o_ds_credit_err_cnt = errcnt_q;
`endif

endmodule

// File: tb/tb_rio_link_credits_nvc.sv
// Bench for rio_link_credits_nvc: directed steps plus a randomized phase against a modulo-arithmetic model.
// Builds with or without RIO_CREDIT_ERRCNT_EN.
module tb_rio_link_credits_nvc;
  localparam int NV = 3, FS = 6, CW = 16, GUARD = 3, THR = 4;

  logic clk = 1'b0, rst_n = 1'b1, rst2_n = 1'b1;
  always #5 clk = ~clk;

  logic [NV-1:0] enq = '0, deq = '0, xoff;
  logic [CW-1:0] ds_credit = '0, us_credit;
  logic ds_valid = 1'b0, us_valid, accept = 1'b0, ds_err;
  logic [NV-1:0] enq2 = '0, deq2 = '0, xoff2;
  logic [CW-1:0] ds_credit2 = '0, us_credit2;
  logic ds_valid2 = 1'b0, us_valid2, accept2 = 1'b1, ds_err2;
`ifdef RIO_CREDIT_ERRCNT_EN
  logic clr = 1'b0, clr2 = 1'b0;
  logic [15:0] cnt, cnt2;
`endif

  rio_link_credits_nvc #(.RETX_PERIOD(0)) dut (
    .clk(clk), .rst_n(rst_n), .i_enq(enq), .i_ds_credit(ds_credit), .i_ds_credit_valid(ds_valid),
    .i_deq(deq),
`ifdef RIO_CREDIT_ERRCNT_EN
    .i_err_cnt_clr(clr), .o_ds_credit_err_cnt(cnt),
`endif
    .o_us_credit(us_credit), .o_us_credit_valid(us_valid), .i_us_credit_accept(accept),
    .o_local_xoff(xoff), .o_ds_credit_err(ds_err));

  rio_link_credits_nvc #(.RETX_PERIOD(16)) dut_rt (
    .clk(clk), .rst_n(rst2_n), .i_enq(enq2), .i_ds_credit(ds_credit2), .i_ds_credit_valid(ds_valid2),
    .i_deq(deq2),
`ifdef RIO_CREDIT_ERRCNT_EN
    .i_err_cnt_clr(clr2), .o_ds_credit_err_cnt(cnt2),
`endif
    .o_us_credit(us_credit2), .o_us_credit_valid(us_valid2), .i_us_credit_accept(accept2),
    .o_local_xoff(xoff2), .o_ds_credit_err(ds_err2));

  int errors = 0, checks = 0, cyc = 0;
  int stab_bad = 0, zero_bad = 0, err_pulses = 0;
  logic [CW-1:0] got_q[$], got2_q[$], exp_q[$];
  int got_t[$], got2_t[$];
  logic prev_hold = 1'b0;
  logic [CW-1:0] prev_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (us_valid && accept) begin got_q.push_back(us_credit); got_t.push_back(cyc); end
    if (us_valid2 && accept2) begin got2_q.push_back(us_credit2); got2_t.push_back(cyc); end
    if (prev_hold && rst_n && (us_valid !== 1'b1 || us_credit !== prev_word)) stab_bad++;
    prev_hold = us_valid && !accept;
    prev_word = us_credit;
    if (!us_valid && us_credit !== '0) zero_bad++;
    if (!us_valid2 && us_credit2 !== '0) zero_bad++;
    if (ds_err === 1'b1) err_pulses++;
  end

  // Independent word builder: fixed layout for CW=16, VC field bits 14:13, pointer bits 2:0.
  function automatic logic [CW-1:0] tb_raw(input int field, input int ptr, input logic [CW-1:0] extra);
    logic [CW-1:0] w;
    logic p;
    w = extra;
    w[2:0] = 3'(ptr);
    w[14:13] = 2'(field);
    p = 1'b0;
    for (int i = 0; i < CW - 1; i++) p ^= w[i];
    w[CW-1] = p;
    return w;
  endfunction

  function automatic logic [CW-1:0] tb_enc(input int vc, input int ptr);
    return tb_raw(vc + 1, ptr, '0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input int which, input int n, input int budget);
    int k;
    k = 0;
    while (((which == 1) ? got_q.size() : got2_q.size()) < n && k < budget) begin
      step();
      k++;
    end
    chk("word_budget", 32'(k < budget), 32'd1);
  endtask

  int hd[NV], tl[NV], ut[NV];
  int exp_pulses, base_pulses, exp_bad, lastp, nz, n2, malformed, idx;
  logic [NV-1:0] exp_x;
  logic [CW-1:0] bad_w[4], w, held;
  logic bad;

  function automatic logic [NV-1:0] model_xoff();
    logic [NV-1:0] x;
    for (int v = 0; v < NV; v++) x[v] = (((hd[v] - tl[v] + FS) % FS) > THR);
    return x;
  endfunction

  initial begin
    for (int v = 0; v < NV; v++) begin hd[v] = 0; tl[v] = 0; ut[v] = 0; end
    #2 rst_n = 1'b0; rst2_n = 1'b0;
    step(); step();
    chk("rst_xoff", 32'(xoff), 32'h7);
    chk("rst_valid", 32'(us_valid), 32'd0);
    chk("rst_credit", 32'(us_credit), 32'd0);
    chk("rst_err", 32'(ds_err), 32'd0);
`ifdef RIO_CREDIT_ERRCNT_EN
    chk("rst_cnt", 32'(cnt), 32'd0);
`endif
    rst_n = 1'b1;
    step(); step();
    chk("xoff_after_rst", 32'(xoff), 32'd0);

    // Five enqueues on VC1, no credits back.
    for (int i = 0; i < 5; i++) begin
      enq = 3'b010; step(); hd[1] = (hd[1] + 1) % FS;
    end
    enq = '0;
    step(); chk("xoff1_n2", 32'(xoff[1]), 32'd0);
    step(); chk("xoff1_n3", 32'(xoff[1]), 32'(model_xoff() >> 1) & 32'd1);
    ds_credit = tb_enc(1, 3); ds_valid = 1'b1; step(); tl[1] = 3; ds_valid = 1'b0;
    step(); chk("xoff1_cr_n2", 32'(xoff[1]), 32'd1);
    step(); chk("xoff_cr_n3", 32'(xoff), 32'(model_xoff()));

    // Rejected credits: parity, VC field 0, reserved bit, pointer out of range.
    bad_w[0] = tb_enc(1, 0) ^ 16'h8000;
    bad_w[1] = tb_raw(0, 1, '0);
    bad_w[2] = tb_raw(2, 0, 16'h0100);
    bad_w[3] = tb_raw(2, 6, '0);
    base_pulses = err_pulses;
    for (int i = 0; i < 4; i++) begin
      ds_credit = bad_w[i]; ds_valid = 1'b1; step(); ds_valid = 1'b0;
      chk($sformatf("err_pulse%0d", i), 32'(ds_err), 32'd1);
      step();
      chk($sformatf("err_drop%0d", i), 32'(ds_err), 32'd0);
    end
    step(); step();
    chk("err_pulse_cnt", 32'(err_pulses - base_pulses), 32'd4);
    chk("xoff_after_bad", 32'(xoff), 32'(model_xoff()));
`ifdef RIO_CREDIT_ERRCNT_EN
    chk("errcnt4", 32'(cnt), 32'd4);
    clr = 1'b1; step(); clr = 1'b0;
    chk("errcnt_clr", 32'(cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      ds_credit = bad_w[i]; ds_valid = 1'b1; step(); ds_valid = 1'b0; step();
    end
    chk("errcnt3", 32'(cnt), 32'd3);
    clr = 1'b1; ds_credit = bad_w[3]; ds_valid = 1'b1; step(); clr = 1'b0; ds_valid = 1'b0;
    chk("errcnt_clr_prio", 32'(cnt), 32'd0);
    step();
`endif

    // One-cycle dequeue on every VC, consumer always ready.
    got_q.delete(); got_t.delete(); exp_q.delete();
    accept = 1'b1; deq = 3'b111; step(); deq = '0;
    for (int v = 0; v < NV; v++) begin ut[v] = (ut[v] + 1) % FS; exp_q.push_back(tb_enc(v, ut[v])); end
    wait_words(1, 3, 60);
    for (int i = 0; i < 3; i++) chk($sformatf("rr_word%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    chk("rr_gap01", 32'(got_t[1] - got_t[0]), 32'(GUARD + 2));
    chk("rr_gap12", 32'(got_t[2] - got_t[1]), 32'(GUARD + 2));
    repeat (8) step();

    // Credit held in SEND while a newer dequeue arrives on the same VC.
    got_q.delete(); got_t.delete(); exp_q.delete();
    accept = 1'b0; deq = 3'b001; step(); deq = '0; ut[0] = (ut[0] + 1) % FS;
    held = tb_enc(0, ut[0]);
    repeat (4) step();
    chk("hold_valid", 32'(us_valid), 32'd1);
    chk("hold_word", 32'(us_credit), 32'(held));
    deq = 3'b001; step(); deq = '0; ut[0] = (ut[0] + 1) % FS;
    repeat (3) step();
    chk("hold_word_after_deq", 32'(us_credit), 32'(held));
    exp_q.push_back(held); exp_q.push_back(tb_enc(0, ut[0]));
    accept = 1'b1;
    wait_words(1, 2, 40);
    chk("hold_first", 32'(got_q[0]), 32'(exp_q[0]));
    chk("hold_second", 32'(got_q[1]), 32'(exp_q[1]));
    repeat (8) step();

    // Randomized traffic on both sides.
    got_q.delete(); got_t.delete();
    base_pulses = err_pulses; exp_bad = 0;
    for (int i = 0; i < 300; i++) begin
      enq = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      deq = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      accept = 1'($urandom_range(0, 1));
      bad = 1'b0; idx = 0;
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, NV - 1);
        lastp = $urandom_range(0, FS - 1);
        bad = ($urandom_range(0, 4) == 0);
        ds_credit = bad ? (tb_enc(idx, lastp) ^ 16'h8000) : tb_enc(idx, lastp);
        ds_valid = 1'b1;
      end else begin
        ds_valid = 1'b0;
      end
      step();
      for (int v = 0; v < NV; v++) begin
        if (enq[v]) hd[v] = (hd[v] + 1) % FS;
        if (deq[v]) ut[v] = (ut[v] + 1) % FS;
      end
      if (ds_valid && !bad) tl[idx] = lastp;
      if (ds_valid && bad) exp_bad++;
    end
    enq = '0; deq = '0; ds_valid = 1'b0; accept = 1'b1;
    repeat (60) step();
    chk("rnd_xoff", 32'(xoff), 32'(model_xoff()));
    chk("rnd_err_pulses", 32'(err_pulses - base_pulses), 32'(exp_bad));
`ifdef RIO_CREDIT_ERRCNT_EN
    chk("rnd_errcnt", 32'(cnt), 32'(exp_bad));
`endif
    malformed = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      w = got_q[i];
      if (w[14:13] == 2'd0 || w[14:13] > 2'(NV) || w[2:0] >= 3'(FS) ||
          w !== tb_enc(int'(w[14:13]) - 1, int'(w[2:0]))) malformed++;
    end
    chk("rnd_malformed", 32'(malformed), 32'd0);
    for (int v = 0; v < NV; v++) begin
      lastp = -1;
      for (int i = 0; i < got_q.size(); i++) if (int'(got_q[i][14:13]) == v + 1) lastp = int'(got_q[i][2:0]);
      chk($sformatf("rnd_last_ptr_vc%0d", v), 32'(lastp), 32'(ut[v]));
    end
    chk("stable_while_held", 32'(stab_bad), 32'd0);
    chk("zero_when_idle", 32'(zero_bad), 32'd0);

    // Retransmit instance: period 16, consumer always ready, no traffic.
    rst2_n = 1'b1;
    got2_q.delete(); got2_t.delete();
    wait_words(2, 9, 120);
    for (int i = 0; i < 9; i++) chk($sformatf("retx_word%0d", i), 32'(got2_q[i]), 32'(tb_enc(i % 3, 0)));
    chk("retx_period_a", 32'(got2_t[3] - got2_t[0]), 32'd16);
    chk("retx_period_b", 32'(got2_t[6] - got2_t[3]), 32'd16);
    for (int i = 0; i < 6; i++) begin deq2 = 3'b100; step(); end
    deq2 = '0;
    repeat (60) step();
    got2_q.delete(); got2_t.delete();
    repeat (48) step();
    nz = 0; n2 = 0;
    for (int i = 0; i < got2_q.size(); i++) begin
      if (got2_q[i][2:0] != 3'd0) nz++;
      if (got2_q[i] === tb_enc(2, 0)) n2++;
    end
    chk("retx_wrap_ptr0", 32'(nz), 32'd0);
    chk("retx_vc2_resent", 32'(n2 >= 2), 32'd1);

    // Asynchronous reset while a credit is being offered.
    accept = 1'b0; deq = 3'b010; step(); deq = '0;
    repeat (3) step();
    chk("pre_rst_valid", 32'(us_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(us_valid), 32'd0);
    chk("async_rst_credit", 32'(us_credit), 32'd0);
    chk("async_rst_xoff", 32'(xoff), 32'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
